// File: rtl/norm_collector.sv
// Packs serial normalized elements from two streams into saturated row words and
// buffers completed rows in a small first-word-fall-through FIFO with a valid/ready output.
module norm_collector #(
  parameter int COL   = 8,
  parameter int W_IN  = 16,
  parameter int W_OUT = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       norm_valid,
  input  logic [W_IN-1:0]            psum_norm_1,
  input  logic [W_IN-1:0]            psum_norm_2,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [COL*W_OUT-1:0]       m_data_1,
  output logic [COL*W_OUT-1:0]       m_data_2,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  output logic [15:0]                row_count
);

  localparam int BW = (COL > 1) ? $clog2(COL) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = COL * W_OUT;

  // Any set bit above the output width means the value exceeds the output range (W_IN > W_OUT).
  function automatic logic [W_OUT-1:0] sat(input logic [W_IN-1:0] x);
    if (x[W_IN-1:W_OUT] != '0) return {W_OUT{1'b1}};
    return x[W_OUT-1:0];
  endfunction

  logic [BW-1:0]    bcnt;
  logic [RW-1:0]    asm_1, asm_2;
  logic [RW-1:0]    row_1, row_2;
  logic [W_OUT-1:0] s1, s2;
  logic [RW-1:0]    mem_1 [DEPTH];
  logic [RW-1:0]    mem_2 [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             valid_q;
  logic             last, push, pop, full, push_ok;

  assign s1      = sat(psum_norm_1);
  assign s2      = sat(psum_norm_2);
  assign last    = (bcnt == BW'(COL - 1));
  assign push    = norm_valid && last;
  assign pop     = valid_q && m_ready;
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && (!full || pop);

  // The final beat bypasses the assembly register so the row is pushed on that same edge.
  always_comb begin
    row_1 = asm_1;
    row_2 = asm_2;
    row_1[(COL-1)*W_OUT +: W_OUT] = s1;
    row_2[(COL-1)*W_OUT +: W_OUT] = s2;
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push_ok)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_q   <= 1'b0;
      overflow  <= 1'b0;
      row_count <= '0;
    end else begin
      if (norm_valid)
        bcnt <= last ? '0 : bcnt + 1'b1;
      if (push_ok) begin
        wr_ptr    <= wr_ptr + 1'b1;
        row_count <= row_count + 16'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok)
        overflow <= 1'b1;
      count   <= count_nxt;
      valid_q <= (count_nxt != '0);
    end
  end

  // Data storage needs no reset: bcnt and the FIFO pointers qualify everything.
  always_ff @(posedge clk) begin
    if (norm_valid) begin
      asm_1[int'(bcnt)*W_OUT +: W_OUT] <= s1;
      asm_2[int'(bcnt)*W_OUT +: W_OUT] <= s2;
    end
    if (push_ok) begin
      mem_1[wr_ptr] <= row_1;
      mem_2[wr_ptr] <= row_2;
    end
  end

  assign m_valid    = valid_q;
  assign m_data_1   = mem_1[rd_ptr];
  assign m_data_2   = mem_2[rd_ptr];
  assign fifo_count = count;

endmodule

// File: doc/norm_collector.md
Name: norm_collector

Overview:
Downstream of the dual-stream normalizer. Packs its serial normalized outputs (one element per stream per norm_valid beat, COL beats per row) into COL-wide row words and saturates each element to W_OUT bits. Buffers completed rows in a small first-word-fall-through FIFO. Presents them to the output writer over a valid/ready handshake.

Parameters:
COL, 8, elements per row; also beats per row.
W_IN, 16, width of incoming normalized element (unsigned).
W_OUT, 8, width of each packed output element (unsigned, saturated).
DEPTH, 4, row FIFO depth in rows; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
norm_valid  input  1  one element beat is valid on psum_norm_1/psum_norm_2.
psum_norm_1  input  W_IN  stream-1 normalized element, unsigned.
psum_norm_2  input  W_IN  stream-2 normalized element, unsigned.
m_valid  output  1  head row available.
m_ready  input  1  consumer accepts head row when m_valid=1.
m_data_1  output  COL*W_OUT  stream-1 row; element k at bits [k*W_OUT +: W_OUT].
m_data_2  output  COL*W_OUT  stream-2 row, same packing.
fifo_count  output  $clog2(DEPTH+1)  rows currently stored.
overflow  output  1  sticky; a completed row was dropped.
row_count  output  16  rows successfully pushed; wraps at 2^16.

Behaviour:
- Reset (synchronous, active-high) sets: m_valid=0, fifo_count=0, overflow=0, row_count=0, beat counter=0, FIFO pointers=0. m_data_1/m_data_2 are don't-care while m_valid=0. Reset mid-row discards the partial row.
- Saturation: sat(x) = (x > 2^W_OUT-1) ? 2^W_OUT-1 : x[W_OUT-1:0]. Inputs are treated as unsigned, so no sign handling.
- Assembly:
  - Beat counter bcnt runs 0..COL-1 and advances only on cycles with norm_valid=1.
  - On each beat, sat(psum_norm_1) is written into assembly lane bcnt of row 1, and sat(psum_norm_2) into lane bcnt of row 2.
  - The first beat after reset or after a completed row is element 0 (LSB lane).
  - Gaps (norm_valid=0) inside a row are allowed; bcnt holds and the lanes hold their contents.
- Row completion:
  - The beat with bcnt==COL-1 completes the row. bcnt wraps to 0.
  - The completed row, including the final beat's element, is pushed into the FIFO on that same clock edge. The push path is direct, so no extra cycle is spent in assembly.
  - A push with room increments row_count.
- FIFO (FWFT):
  - Pop occurs on m_valid & m_ready.
  - m_valid = (fifo_count != 0), driven from a register.
  - m_data_1/m_data_2 show the head entry and stay stable while m_valid=1 and m_ready=0.
- Latency: final beat at edge t, FIFO previously empty, gives m_valid=1 after edge t, with the row on m_data.
- Boundary conditions:
  - Full (fifo_count==DEPTH), row completes, no pop the same cycle: the row is dropped; overflow is set and stays set until reset; row_count and fifo_count are unchanged.
  - Full, row completes, pop the same cycle: the push succeeds and fifo_count stays DEPTH.
  - Empty FIFO with m_ready=1: no pop; count never underflows.
  - Simultaneous push and pop at a nonzero count: count is unchanged and the pointers both advance.
  - Pointers wrap modulo DEPTH.
  - row_count wraps 0xFFFF -> 0x0000.
- Back-to-back rows: norm_valid may stay high for many rows; bcnt wraps continuously without a dead cycle.

Test Plan:
1. Single row (COL=8, W_OUT=8): norm_valid high for 8 cycles with psum_norm_1 = 0..7 and psum_norm_2 = 10..17, m_ready=1 -> one cycle after the last beat, m_valid=1, m_data_1=0x0706050403020100, m_data_2=0x11100F0E0D0C0B0A, row_count=1.
2. Saturation: element values 255, 256, 300, 0xFFFF, 1 on stream 1 -> packed lanes read 0xFF, 0xFF, 0xFF, 0xFF, 0x01.
3. Gapped beats: 8 beats interleaved with random idle cycles -> same packed row as scenario 1. No push before the 8th beat; fifo_count stays 0 until it.
4. Backpressure and overflow (DEPTH=4): m_ready=0 while 5 rows stream -> fifo_count=4 and overflow=1 after row 5; row_count=4. Then m_ready=1 drains rows 1-4 in order with data held stable during the stall.
5. Push and pop while full: fifo_count=4, row 5 completes on the same cycle as a pop -> fifo_count stays 4, overflow=0, row 5 appears last in the drained order.
6. Reset mid-row: 3 beats, then a 1-cycle reset, then 8 fresh beats of value 0x20 -> a single row, all lanes 0x20. fifo_count=1, row_count=1, overflow=0.
